// File: rtl/xpoint_input_port_pkg.sv
// Shared definitions for the crossbar input port: flit field positions,
// default geometry and the port FSM state type.
package xpoint_input_port_pkg;

    localparam int unsigned FLIT_SIZE_DEF = 64;
    localparam int unsigned COORD_W_DEF   = 4;

    // Flit layout from the MSB down: head, tail, dst_x, dst_y, payload.
    function automatic int unsigned head_bit(input int unsigned fs);
        return fs - 1;
    endfunction

    function automatic int unsigned tail_bit(input int unsigned fs);
        return fs - 2;
    endfunction

    function automatic int unsigned dstx_msb(input int unsigned fs);
        return fs - 3;
    endfunction

    function automatic int unsigned dsty_msb(input int unsigned fs, input int unsigned cw);
        return fs - 3 - cw;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_LOCK = 2'd2
    } state_t;

endpackage

// File: rtl/xpoint_input_port_flit_fifo.sv
// Circular flit buffer with occupancy count. A push while full is accepted
// only when a pop frees a slot in the same cycle.
module flit_fifo #(
    parameter int unsigned FLIT_SIZE = 64,
    parameter int unsigned BUF_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic [FLIT_SIZE-1:0]         i_din,
    output logic [FLIT_SIZE-1:0]         o_dout,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(BUF_DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(BUF_DEPTH);

    logic [FLIT_SIZE-1:0] r_mem [BUF_DEPTH];
    logic [AW-1:0]        r_wr;
    logic [AW-1:0]        r_rd;
    logic [AW:0]          r_cnt;
    logic                 w_push_ok;
    logic                 w_pop_ok;

    assign o_full    = (r_cnt == (AW+1)'(BUF_DEPTH));
    assign o_empty   = (r_cnt == '0);
    assign o_count   = r_cnt;
    assign w_push_ok = i_push && (!o_full || i_pop);
    assign w_pop_ok  = i_pop && !o_empty;
    assign o_dout    = o_empty ? '0 : r_mem[r_rd];

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr] <= i_din;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push_ok) r_wr <= r_wr + AW'(1);
            if (w_pop_ok)  r_rd <= r_rd + AW'(1);
            if (w_push_ok && !w_pop_ok)      r_cnt <= r_cnt + (AW+1)'(1);
            else if (!w_push_ok && w_pop_ok) r_cnt <= r_cnt - (AW+1)'(1);
        end
    end

endmodule

// File: rtl/xpoint_input_port.sv
// Router input port: buffers flits, routes head flits X-then-Y, holds the
// route for the whole wormhole packet and returns one credit per forwarded flit.
module xpoint_input_port
    import xpoint_input_port_pkg::*;
#(
    parameter int unsigned FLIT_SIZE = xpoint_input_port_pkg::FLIT_SIZE_DEF,
    parameter int unsigned BUF_DEPTH = 4,
    parameter int unsigned COORD_W   = xpoint_input_port_pkg::COORD_W_DEF,
    parameter int unsigned CUR_X     = 0,
    parameter int unsigned CUR_Y     = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [FLIT_SIZE-1:0] in_flit,
    output logic                 credit_out,
    output logic [FLIT_SIZE-1:0] out_flit,
    output logic                 out_req,
    output logic                 out_turn,
    input  logic                 out_grant,
    output logic                 err_ovf,
    output logic                 err_hdr
);

    localparam int unsigned CW       = $clog2(BUF_DEPTH);
    localparam int unsigned HEAD_BIT = head_bit(FLIT_SIZE);
    localparam int unsigned TAIL_BIT = tail_bit(FLIT_SIZE);
    localparam int unsigned DSTX_MSB = dstx_msb(FLIT_SIZE);
    localparam int unsigned DSTY_MSB = dsty_msb(FLIT_SIZE, COORD_W);

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_req;
    logic                 r_turn;
    logic                 r_credit;
    logic                 r_err_ovf;
    logic                 r_err_hdr;
    logic                 w_req_nxt;

    logic [FLIT_SIZE-1:0] w_head_flit;
    logic                 w_full;
    logic                 w_empty;
    logic [CW:0]          w_count;
    logic [CW:0]          w_count_nxt;
    logic                 w_is_head;
    logic                 w_is_tail;
    logic                 w_route_turn;
    logic                 w_unused_eject;
    logic                 w_drop;
    logic                 w_xfer;
    logic                 w_pop;
    logic                 w_push_acc;
    logic                 w_route_load;

    flit_fifo #(
        .FLIT_SIZE (FLIT_SIZE),
        .BUF_DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (in_valid),
        .i_pop   (w_pop),
        .i_din   (in_flit),
        .o_dout  (w_head_flit),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign w_is_head    = w_head_flit[HEAD_BIT];
    assign w_is_tail    = w_head_flit[TAIL_BIT];
    assign w_route_turn = (w_head_flit[DSTX_MSB -: COORD_W] == COORD_W'(CUR_X));
    // dst_y only decides ejection further along the vertical path.
    assign w_unused_eject = w_route_turn &&
                            (w_head_flit[DSTY_MSB -: COORD_W] == COORD_W'(CUR_Y));

    assign w_route_load = (r_state == ST_IDLE) && !w_empty && w_is_head;
    assign w_drop       = (r_state == ST_IDLE) && !w_empty && !w_is_head;
    assign w_xfer       = r_req && out_grant;
    assign w_pop        = w_drop || w_xfer;
    assign w_push_acc   = in_valid && (!w_full || w_pop);

    // Occupancy after this edge, so the registered request matches the FIFO.
    always_comb begin
        w_count_nxt = w_count;
        if (w_push_acc && !w_pop)      w_count_nxt = w_count + (CW+1)'(1);
        else if (!w_push_acc && w_pop) w_count_nxt = w_count - (CW+1)'(1);
    end

    // Next-state and next-request decode.
    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = 1'b0;
        unique case (r_state)
            ST_IDLE: if (w_route_load) w_state_nxt = ST_REQ;
            ST_REQ:  if (w_xfer) w_state_nxt = w_is_tail ? ST_IDLE : ST_LOCK;
            ST_LOCK: if (w_xfer && w_is_tail) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
        // out_req is registered from the next state so it never glitches.
        w_req_nxt = (w_state_nxt == ST_REQ) ||
                    ((w_state_nxt == ST_LOCK) && (w_count_nxt != '0));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Registered allocator outputs, credit pulse and sticky error flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_req     <= 1'b0;
            r_turn    <= 1'b0;
            r_credit  <= 1'b0;
            r_err_ovf <= 1'b0;
            r_err_hdr <= 1'b0;
        end else begin
            r_req    <= w_req_nxt;
            r_credit <= w_xfer;
            if (w_route_load) r_turn <= w_route_turn;
            if (in_valid && w_full && !w_pop) r_err_ovf <= 1'b1;
            if (w_drop) r_err_hdr <= 1'b1;
        end
    end

    assign out_flit   = w_head_flit;
    assign out_req    = r_req;
    assign out_turn   = r_turn;
    assign credit_out = r_credit;
    assign err_ovf    = r_err_ovf;
    assign err_hdr    = r_err_hdr;

endmodule

// File: tb/tb_xpoint_input_port.sv
// Scoreboard bench for xpoint_input_port at router (2,1).
module tb_xpoint_input_port;

    localparam int unsigned FS = 64;

    typedef struct {
        logic [FS-1:0] flit;
        logic          turn;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [FS-1:0] in_flit = '0;
    logic          credit_out;
    logic [FS-1:0] out_flit;
    logic          out_req;
    logic          out_turn;
    logic          out_grant = 1'b0;
    logic          err_ovf;
    logic          err_hdr;

    exp_t q_exp[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   n_cred = 0;
    bit   mon_en = 1'b0;
    bit   xfer_prev = 1'b0;

    xpoint_input_port #(
        .FLIT_SIZE (64),
        .BUF_DEPTH (4),
        .COORD_W   (4),
        .CUR_X     (2),
        .CUR_Y     (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_flit    (in_flit),
        .credit_out (credit_out),
        .out_flit   (out_flit),
        .out_req    (out_req),
        .out_turn   (out_turn),
        .out_grant  (out_grant),
        .err_ovf    (err_ovf),
        .err_hdr    (err_hdr)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [FS-1:0] act, input logic [FS-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [FS-1:0] mk(input logic h, input logic t, input logic [3:0] dx,
                                         input logic [3:0] dy, input logic [31:0] pl);
        logic [FS-1:0] f;
        f          = '0;
        f[63]      = h;
        f[62]      = t;
        f[61:58]   = dx;
        f[57:54]   = dy;
        f[31:0]    = pl;
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [FS-1:0] f);
        in_valid = 1'b1;
        in_flit  = f;
        tick();
        in_valid = 1'b0;
        in_flit  = '0;
    endtask

    task automatic sb(input logic [FS-1:0] f, input logic turn);
        exp_t e;
        e.flit = f;
        e.turn = turn;
        q_exp.push_back(e);
    endtask

    task automatic wait_drain(input int unsigned max_cyc);
        for (int unsigned i = 0; i < max_cyc && q_exp.size() != 0; i++) tick();
        if (q_exp.size() != 0) begin
            n_chk++;
            n_err++;
            $display("FAIL drain_timeout: %0d flits still expected", q_exp.size());
            q_exp.delete();
        end
        tick();
        tick();
    endtask

    // Monitor: compares each transfer against the scoreboard and checks
    // that a credit follows exactly the cycles with a transfer.
    always @(negedge clk) begin : mon
        exp_t e;
        if (mon_en) begin
            check("credit_out", {63'd0, credit_out}, {63'd0, xfer_prev});
            if (credit_out === 1'b1) n_cred++;
            xfer_prev = (out_req === 1'b1) && (out_grant === 1'b1) && (rst_n === 1'b1);
            if (xfer_prev) begin
                if (q_exp.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL unexpected_xfer: got flit %h expected none", out_flit);
                end else begin
                    e = q_exp.pop_front();
                    check("xfer_flit", out_flit, e.flit);
                    check("xfer_turn", {63'd0, out_turn}, {63'd0, e.turn});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        logic [FS-1:0] h3;

        // Reset state
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_req",   {63'd0, out_req},    '0);
        check("rst_turn",  {63'd0, out_turn},   '0);
        check("rst_cred",  {63'd0, credit_out}, '0);
        check("rst_flit",  out_flit,            '0);
        check("rst_ovf",   {63'd0, err_ovf},    '0);
        check("rst_hdr",   {63'd0, err_hdr},    '0);
        check("rst_count", 64'(dut.u_fifo.o_count), '0);
        mon_en = 1'b1;
        rst_n  = 1'b1;
        tick();

        // 1: single-flit packet, dst_x == CUR_X, request two cycles after push
        out_grant = 1'b1;
        c0 = n_cred;
        sb(mk(1, 1, 4'd2, 4'd1, 32'hA001), 1'b1);
        push1(mk(1, 1, 4'd2, 4'd1, 32'hA001));
        check("t1_req_early", {63'd0, out_req}, '0);
        tick();
        check("t1_req_rise", {63'd0, out_req}, 64'd1);
        check("t1_turn", {63'd0, out_turn}, 64'd1);
        wait_drain(20);
        check("t1_credits", 64'(n_cred - c0), 64'd1);

        // 2: 4-flit straight packet back-to-back, one flit per cycle
        c0 = n_cred;
        sb(mk(1, 0, 4'd5, 4'd3, 32'hB000), 1'b0);
        sb(mk(0, 0, 4'd5, 4'd3, 32'hB001), 1'b0);
        sb(mk(0, 0, 4'd5, 4'd3, 32'hB002), 1'b0);
        sb(mk(0, 1, 4'd5, 4'd3, 32'hB003), 1'b0);
        push1(mk(1, 0, 4'd5, 4'd3, 32'hB000));
        push1(mk(0, 0, 4'd5, 4'd3, 32'hB001));
        push1(mk(0, 0, 4'd5, 4'd3, 32'hB002));
        push1(mk(0, 1, 4'd5, 4'd3, 32'hB003));
        tick();
        tick();
        check("t2_pipelined", 64'(q_exp.size()), '0);
        check("t2_idle_req", {63'd0, out_req}, '0);
        wait_drain(20);
        check("t2_credits", 64'(n_cred - c0), 64'd4);
        check("t2_count", 64'(dut.u_fifo.o_count), '0);

        // 3: fill with no grant, overflow, then push+pop at full
        out_grant = 1'b0;
        c0 = n_cred;
        h3 = mk(1, 0, 4'd2, 4'd7, 32'hC000);
        sb(h3, 1'b1);
        sb(mk(0, 0, 4'd2, 4'd7, 32'hC001), 1'b1);
        sb(mk(0, 0, 4'd2, 4'd7, 32'hC002), 1'b1);
        sb(mk(0, 0, 4'd2, 4'd7, 32'hC003), 1'b1);
        push1(h3);
        push1(mk(0, 0, 4'd2, 4'd7, 32'hC001));
        push1(mk(0, 0, 4'd2, 4'd7, 32'hC002));
        push1(mk(0, 0, 4'd2, 4'd7, 32'hC003));
        check("t3_full_count", 64'(dut.u_fifo.o_count), 64'd4);
        check("t3_ovf_before", {63'd0, err_ovf}, '0);
        push1(mk(0, 0, 4'd2, 4'd7, 32'hDEAD));
        check("t3_ovf_set", {63'd0, err_ovf}, 64'd1);
        check("t3_count_keep", 64'(dut.u_fifo.o_count), 64'd4);
        check("t3_head_keep", out_flit, h3);
        check("t3_no_credit", 64'(n_cred - c0), '0);
        sb(mk(0, 1, 4'd2, 4'd7, 32'hC004), 1'b1);
        out_grant = 1'b1;
        push1(mk(0, 1, 4'd2, 4'd7, 32'hC004));
        out_grant = 1'b0;
        check("t3_pushpop_full", 64'(dut.u_fifo.o_count), 64'd4);
        out_grant = 1'b1;
        wait_drain(30);
        check("t3_credits", 64'(n_cred - c0), 64'd5);

        // 4: stray body flit at head while idle is dropped without credit
        c0 = n_cred;
        check("t4_hdr_before", {63'd0, err_hdr}, '0);
        push1(mk(0, 0, 4'd2, 4'd2, 32'hE000));
        sb(mk(1, 1, 4'd7, 4'd2, 32'hE001), 1'b0);
        push1(mk(1, 1, 4'd7, 4'd2, 32'hE001));
        wait_drain(20);
        check("t4_hdr_set", {63'd0, err_hdr}, 64'd1);
        check("t4_credits", 64'(n_cred - c0), 64'd1);

        // 5: LOCK with an empty FIFO keeps the route, no re-route on resume
        c0 = n_cred;
        sb(mk(1, 0, 4'd2, 4'd0, 32'hF000), 1'b1);
        push1(mk(1, 0, 4'd2, 4'd0, 32'hF000));
        tick();
        tick();
        tick();
        check("t5_req_gap", {63'd0, out_req}, '0);
        check("t5_turn_gap", {63'd0, out_turn}, 64'd1);
        sb(mk(0, 0, 4'd7, 4'd0, 32'hF001), 1'b1);
        push1(mk(0, 0, 4'd7, 4'd0, 32'hF001));
        check("t5_req_resume", {63'd0, out_req}, 64'd1);
        check("t5_turn_resume", {63'd0, out_turn}, 64'd1);
        tick();
        tick();
        sb(mk(0, 1, 4'd7, 4'd0, 32'hF002), 1'b1);
        push1(mk(0, 1, 4'd7, 4'd0, 32'hF002));
        wait_drain(20);
        check("t5_credits", 64'(n_cred - c0), 64'd3);

        // 6: reset mid-packet discards buffered flits
        out_grant = 1'b0;
        push1(mk(1, 0, 4'd2, 4'd4, 32'h6000));
        push1(mk(0, 0, 4'd2, 4'd4, 32'h6001));
        push1(mk(0, 0, 4'd2, 4'd4, 32'h6002));
        check("t6_count3", 64'(dut.u_fifo.o_count), 64'd3);
        c0 = n_cred;
        rst_n = 1'b0;
        tick();
        check("t6_req",   {63'd0, out_req},    '0);
        check("t6_turn",  {63'd0, out_turn},   '0);
        check("t6_cred",  {63'd0, credit_out}, '0);
        check("t6_flit",  out_flit,            '0);
        check("t6_ovf",   {63'd0, err_ovf},    '0);
        check("t6_hdr",   {63'd0, err_hdr},    '0);
        check("t6_count", 64'(dut.u_fifo.o_count), '0);
        rst_n = 1'b1;
        out_grant = 1'b1;
        tick();
        sb(mk(1, 0, 4'd9, 4'd4, 32'h6100), 1'b0);
        sb(mk(0, 1, 4'd9, 4'd4, 32'h6101), 1'b0);
        push1(mk(1, 0, 4'd9, 4'd4, 32'h6100));
        push1(mk(0, 1, 4'd9, 4'd4, 32'h6101));
        wait_drain(20);
        check("t6_credits", 64'(n_cred - c0), 64'd2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
